// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber and port arbiter for one SEC-DED
// protected single-port SRAM bank. The host always wins the port; the scrub
// engine reads each word through the external decoder, writes corrected
// words back through the external encoder, and logs uncorrectable words.
// Optional macro ECC_SCRUB_STATS_EN adds saturating corr_cnt / uncorr_cnt.
module ecc_scrub_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int PARITY_LENGTH  = 6,
   parameter int ADDR_WIDTH     = 10,
   parameter int DEPTH          = 1024,
   parameter int INTERVAL_WIDTH = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      scrub_en,
   input  logic [INTERVAL_WIDTH-1:0] scrub_interval,
   input  logic                      host_req,
   input  logic                      host_we,
   input  logic [ADDR_WIDTH-1:0]     host_addr,
   output logic                      host_gnt,
   output logic                      scr_sel,
   output logic                      scr_en,
   output logic                      scr_we,
   output logic [ADDR_WIDTH-1:0]     scr_addr,
   output logic [DATA_WIDTH-1:0]     scr_wdata,
   input  logic [PARITY_LENGTH-1:0]  enc_parity_in,
   input  logic                      enc_oe_in,
   output logic [PARITY_LENGTH-1:0]  scr_wparity,
   output logic                      scr_woe,
   input  logic [DATA_WIDTH-1:0]     dec_data_in,
   input  logic [2:0]                dec_label_in,
   output logic                      pass_done,
   output logic                      irq_uncorr,
   input  logic                      irq_clr,
`ifdef ECC_SCRUB_STATS_EN
   output logic [CNT_WIDTH-1:0]      corr_cnt,
   output logic [CNT_WIDTH-1:0]      uncorr_cnt,
`endif
   output logic [ADDR_WIDTH-1:0]     last_uncorr_addr
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_RD, S_W1, S_W2, S_CHK, S_WB, S_NEXT
   } state_t;

   localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [INTERVAL_WIDTH-1:0] INT_ONE   = INTERVAL_WIDTH'(1);

   state_t                    r_state;
   state_t                    w_state_next;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [INTERVAL_WIDTH-1:0] r_interval_cnt;
   logic                      r_hazard;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic                      r_irq;
   logic [ADDR_WIDTH-1:0]     r_last_uncorr;

   logic w_scr_sel;
   logic w_scr_we;
   logic w_load_interval;
   logic w_issue_rd;
   logic w_latch_fix;
   logic w_log_uncorr;
   logic w_advance;
   logic w_host_hit;
   logic w_in_window;
   logic w_at_last;
   logic w_label_fix;
   logic w_label_uncorr;

   // A host write to the word in flight makes the read data stale
   assign w_host_hit     = host_req & host_we & (host_addr == r_addr);
   assign w_in_window    = (r_state == S_W1) || (r_state == S_W2) ||
                           (r_state == S_CHK) || (r_state == S_WB);
   assign w_at_last      = (r_addr == LAST_ADDR);
   assign w_label_fix    = (dec_label_in == 3'd2) || (dec_label_in == 3'd4);
   assign w_label_uncorr = (dec_label_in == 3'd3);

   // Next-state and access decode; the host request always blocks the scrubber
   always_comb begin
      w_state_next    = r_state;
      w_scr_sel       = 1'b0;
      w_scr_we        = 1'b0;
      w_load_interval = 1'b0;
      w_issue_rd      = 1'b0;
      w_latch_fix     = 1'b0;
      w_log_uncorr    = 1'b0;
      w_advance       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (scrub_en) begin
               w_load_interval = 1'b1;
               w_state_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_interval_cnt == '0) w_state_next = S_RD;
         end
         S_RD: begin
            if (!host_req) begin
               w_scr_sel    = 1'b1;
               w_issue_rd   = 1'b1;
               w_state_next = S_W1;
            end
         end
         S_W1: w_state_next = S_W2;
         S_W2: w_state_next = S_CHK;
         S_CHK: begin
            if (r_hazard) begin
               w_state_next = S_RD;
            end else if (w_label_fix) begin
               w_latch_fix  = 1'b1;
               w_state_next = S_WB;
            end else begin
               w_log_uncorr = w_label_uncorr;
               w_state_next = S_NEXT;
            end
         end
         S_WB: begin
            if (!host_req) begin
               if (r_hazard) begin
                  w_state_next = S_RD;
               end else begin
                  w_scr_sel    = 1'b1;
                  w_scr_we     = 1'b1;
                  w_state_next = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            w_advance = 1'b1;
            if (scrub_en) begin
               w_load_interval = 1'b1;
               w_state_next    = S_WAIT;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Idle-gap counter, loaded on every entry to WAIT
   always_ff @(posedge clk) begin
      if (rst)                                           r_interval_cnt <= '0;
      else if (w_load_interval)                          r_interval_cnt <= scrub_interval;
      else if (r_state == S_WAIT && r_interval_cnt != '0) r_interval_cnt <= r_interval_cnt - INT_ONE;
   end

   // Scrub address walks 0..DEPTH-1 and wraps; kept across disable
   always_ff @(posedge clk) begin
      if (rst)            r_addr <= '0;
      else if (w_advance) r_addr <= w_at_last ? '0 : (r_addr + ADDR_ONE);
   end

   // Hazard flag: cleared when a read is issued, set by a colliding host write
   always_ff @(posedge clk) begin
      if (rst)                            r_hazard <= 1'b0;
      else if (w_issue_rd)                r_hazard <= 1'b0;
      else if (w_in_window && w_host_hit) r_hazard <= 1'b1;
   end

   // Corrected data held for the write-back
   always_ff @(posedge clk) begin
      if (rst)              r_wdata <= '0;
      else if (w_latch_fix) r_wdata <= dec_data_in;
   end

   // Uncorrectable logging; a new event beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq         <= 1'b0;
         r_last_uncorr <= '0;
      end else if (w_log_uncorr) begin
         r_irq         <= 1'b1;
         r_last_uncorr <= r_addr;
      end else if (irq_clr) begin
         r_irq <= 1'b0;
      end
   end

`ifdef ECC_SCRUB_STATS_EN
   logic [CNT_WIDTH-1:0] r_corr_cnt;
   logic [CNT_WIDTH-1:0] r_uncorr_cnt;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Saturating error statistics, only for hazard-free checks
   always_ff @(posedge clk) begin
      if (rst) begin
         r_corr_cnt   <= '0;
         r_uncorr_cnt <= '0;
      end else begin
         if (w_latch_fix && r_corr_cnt != '1)    r_corr_cnt   <= r_corr_cnt + CNT_ONE;
         if (w_log_uncorr && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + CNT_ONE;
      end
   end

   assign corr_cnt   = r_corr_cnt;
   assign uncorr_cnt = r_uncorr_cnt;
`endif

   assign host_gnt         = host_req;
   assign scr_sel          = w_scr_sel;
   assign scr_en           = w_scr_sel;
   assign scr_we           = w_scr_we;
   assign scr_addr         = r_addr;
   assign scr_wdata        = r_wdata;
   assign scr_wparity      = enc_parity_in;
   assign scr_woe          = enc_oe_in;
   assign pass_done        = (r_state == S_NEXT) && w_at_last;
   assign irq_uncorr       = r_irq;
   assign last_uncorr_addr = r_last_uncorr;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Testbench for ecc_scrub_ctrl: emulates the SRAM, SEC-DED decoder and encoder,
// plans each scrub pass from the memory's error map and checks the stream of
// scrubber accesses and pass_done pulses through a scoreboard queue.
module tb_ecc_scrub_ctrl;
   localparam int DW = 32, PL = 6, AW = 4, DEPTH = 16, IW = 16, CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, scrub_en, host_req, host_we, irq_clr;
   logic [IW-1:0] scrub_interval;
   logic [AW-1:0] host_addr, scr_addr, last_uncorr_addr;
   logic          host_gnt, scr_sel, scr_en, scr_we, scr_woe, enc_oe_in, pass_done, irq_uncorr;
   logic [DW-1:0] scr_wdata, dec_data_in;
   logic [PL-1:0] enc_parity_in, scr_wparity;
   logic [2:0]    dec_label_in;
`ifdef ECC_SCRUB_STATS_EN
   logic [CW-1:0] corr_cnt, uncorr_cnt;
`endif

   ecc_scrub_ctrl #(.DATA_WIDTH(DW), .PARITY_LENGTH(PL), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                    .INTERVAL_WIDTH(IW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_gnt(host_gnt),
      .scr_sel(scr_sel), .scr_en(scr_en), .scr_we(scr_we), .scr_addr(scr_addr),
      .scr_wdata(scr_wdata), .enc_parity_in(enc_parity_in), .enc_oe_in(enc_oe_in),
      .scr_wparity(scr_wparity), .scr_woe(scr_woe), .dec_data_in(dec_data_in),
      .dec_label_in(dec_label_in), .pass_done(pass_done), .irq_uncorr(irq_uncorr),
      .irq_clr(irq_clr),
`ifdef ECC_SCRUB_STATS_EN
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
`endif
      .last_uncorr_addr(last_uncorr_addr));

   // Encoder emulation: a simple parity folding of the write data
   function automatic logic [PL-1:0] par_fn(input logic [DW-1:0] d);
      logic [PL-1:0] p;
      p = '0;
      for (int i = 0; i < DW; i++) p[i % PL] = p[i % PL] ^ d[i];
      return p;
   endfunction
   assign enc_parity_in = par_fn(scr_wdata);
   assign enc_oe_in     = ^scr_wdata;

   int n_cmp = 0, n_bad = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Memory emulation: good data plus an error kind (0 clean, 1 single, 2 double, 3 overall bit)
   logic [DW-1:0] mem_good [DEPTH];
   int            mem_err  [DEPTH];

   // Scoreboard: kind 0 read, 1 write, 2 pass_done
   typedef struct { int kind; int addr; logic [DW-1:0] data; } exp_t;
   exp_t q[$];
   int corr_exp = 0, uncorr_exp = 0, last_unc_exp = 0;
   bit irq_exp = 0;

   // Reference plan for one full pass: every address read once, fixable words written back
   task automatic plan_pass(input int hz_addr);
      exp_t e;
      int k;
      for (int a = 0; a < DEPTH; a++) begin
         e.kind = 0; e.addr = a; e.data = '0;
         q.push_back(e);
         k = mem_err[a];
         if (a == hz_addr) begin
            q.push_back(e);   // stale first read is discarded, word re-read after the host write
            k = 0;
         end
         if (k == 1 || k == 3) begin
            e.kind = 1; e.data = mem_good[a];
            q.push_back(e);
            corr_exp++;
         end else if (k == 2) begin
            uncorr_exp++; last_unc_exp = a; irq_exp = 1;
         end
      end
      e.kind = 2; e.addr = DEPTH - 1; e.data = '0;
      q.push_back(e);
   endtask

   // Decoder request captured at a read, delivered two cycles later
   bit            rec_v = 0, s1_v = 0;
   int            rec_lbl, s1_lbl, rec_addr, s1_addr;
   logic [DW-1:0] rec_data, s1_data;
   bit            clr_on_unc = 0;
   int            clr_stage = 0, clr_addr = 0;

   // Monitor: per-cycle arbitration checks and scoreboard pops
   initial begin
      exp_t e;
      int a;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("host_gnt", host_gnt, host_req);
            if (host_req) check("sel_while_host", scr_sel, 1'b0);
            if (scr_sel && scr_en) begin
               a = int'(scr_addr);
               if (q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_access: got we=%0d addr=%0d required none", scr_we, a);
               end else begin
                  e = q.pop_front();
                  check("access_kind", {63'd0, scr_we}, e.kind);
                  check("access_addr", scr_addr, e.addr);
                  if (e.kind == 1 && scr_we) begin
                     check("wb_data", scr_wdata, e.data);
                     check("wb_parity", scr_wparity, par_fn(e.data));
                     check("wb_oe", scr_woe, ^e.data);
                  end
               end
               if (scr_we) mem_err[a] = 0;
               else begin
                  rec_v = 1; rec_addr = a; rec_lbl = mem_err[a] + 1;
                  rec_data = (mem_err[a] == 2) ? DW'($urandom) : mem_good[a];
               end
            end
            if (pass_done) begin
               if (q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_pass_done: got pulse required none");
               end else begin
                  e = q.pop_front();
                  check("pass_done_slot", 64'(e.kind), 64'd2);
               end
            end
         end
      end
   end

   // Decoder emulation (registered, holds its output) and same-cycle irq_clr probe
   initial begin
      dec_label_in = 3'd0; dec_data_in = '0;
      forever begin
         @(posedge clk); #1;
         if (clr_stage == 2) begin
            irq_clr = 0;
            check("irq_set_wins", irq_uncorr, 1'b1);
            check("last_uncorr_at_clr", last_uncorr_addr, clr_addr);
            clr_stage = 0;
         end else if (clr_stage == 1) begin
            irq_clr = 1;
            clr_stage = 2;
         end
         if (s1_v) begin
            dec_label_in = 3'(s1_lbl);
            dec_data_in  = s1_data;
            if (s1_lbl == 3 && clr_on_unc) begin
               clr_on_unc = 0; clr_stage = 1; clr_addr = s1_addr;
            end
         end
         s1_v = rec_v; s1_lbl = rec_lbl; s1_data = rec_data; s1_addr = rec_addr;
         rec_v = 0;
      end
   end

   // Random host reads unless a directed scenario owns the host port
   bit host_ovr = 1;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!host_ovr) begin
            host_req  = ($urandom_range(0, 3) == 0);
            host_we   = 0;
            host_addr = AW'($urandom_range(0, DEPTH - 1));
         end
      end
   end

   task automatic drain(input string name);
      int i;
      i = 0;
      while (q.size() != 0 && i < 3000) begin
         @(negedge clk); #1;
         i++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_timeout: got %0d pending required 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic wait_read(input int a);
      bit ok;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (scr_sel && scr_en && !scr_we && int'(scr_addr) == a) ok = 1;
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL wait_read_%0d: got no read required read", a);
      end
   endtask

   task automatic check_status(input string name);
      check({name, "_irq"}, irq_uncorr, irq_exp);
      check({name, "_last_uncorr"}, last_uncorr_addr, last_unc_exp);
`ifdef ECC_SCRUB_STATS_EN
      check({name, "_corr_cnt"}, corr_cnt, corr_exp);
      check({name, "_uncorr_cnt"}, uncorr_cnt, uncorr_exp);
`endif
   endtask

   initial begin
      int cnt;
      rst = 1; scrub_en = 0; scrub_interval = 16'd2; irq_clr = 0;
      host_req = 0; host_we = 0; host_addr = '0;
      for (int a = 0; a < DEPTH; a++) begin
         mem_good[a] = DW'($urandom); mem_err[a] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_scr_sel", scr_sel, 1'b0);
      check("rst_scr_we", scr_we, 1'b0);
      check("rst_scr_addr", scr_addr, '0);
      check("rst_scr_wdata", scr_wdata, '0);
      check("rst_pass_done", pass_done, 1'b0);
      check_status("rst");
      @(posedge clk); #1;
      rst = 0; host_ovr = 0;

      // Pass 1: clean memory, 16 reads and no writes
      plan_pass(-1);
      scrub_en = 1;
      drain("pass1");
      check_status("pass1");

      // Pass 2: single error at 5, double error at 9, random errors elsewhere
      for (int a = 0; a < DEPTH; a++) begin
         cnt = $urandom_range(0, 7);
         mem_err[a] = (cnt <= 3) ? cnt : 0;
      end
      mem_err[5] = 1; mem_err[9] = 2;
      scrub_interval = IW'($urandom_range(0, 3));
      plan_pass(-1);
      drain("pass2");
      check_status("pass2");

      // Pass 3: directed irq, enable-drop, host-hold and hazard scenarios
      for (int a = 0; a < DEPTH; a++) mem_err[a] = 0;
      mem_err[3] = 2; mem_err[13] = 1;
      scrub_interval = 16'd2;
      plan_pass(13);
      @(posedge clk); #1 irq_clr = 1;
      @(posedge clk); #1 irq_clr = 0;
      @(negedge clk);
      check("irq_after_clr", irq_uncorr, 1'b0);
      clr_on_unc = 1;

      wait_read(7);
      @(posedge clk); #1 scrub_en = 0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (scr_sel) cnt++;
      end
      check("idle_after_disable", 64'(cnt), 64'd0);
      scrub_en = 1;

      wait_read(10);
      host_ovr = 1;
      @(posedge clk); #1 host_req = 1; host_we = 0; host_addr = '0;
      repeat (19) @(posedge clk);
      @(posedge clk); #1 host_req = 0;
      @(negedge clk);
      check("rd_after_hold_sel", scr_sel, 1'b1);
      check("rd_after_hold_addr", scr_addr, 4'd11);
      host_ovr = 0;

      wait_read(13);
      host_ovr = 1;
      @(posedge clk); #1 host_req = 0; host_we = 0;
      @(posedge clk); #1 host_req = 1; host_we = 1; host_addr = 4'd13;
      mem_good[13] = DW'($urandom); mem_err[13] = 0;
      @(posedge clk); #1 host_req = 0; host_we = 0;
      host_ovr = 0;
      drain("pass3");
      check_status("pass3");

      // Pass 4: fully random error map and interval, engine stopped at the end
      for (int a = 0; a < DEPTH; a++) mem_err[a] = $urandom_range(0, 3);
      scrub_interval = IW'($urandom_range(0, 3));
      plan_pass(-1);
      drain("pass4");
      scrub_en = 0;
      check_status("pass4");
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
- Background memory scrubber and port arbiter for one single-port ECC-protected SRAM bank of the shared CGRA memory.
- Shares the bank's port between the host requester, which always has priority, and its own scrub engine.
- The scrub engine walks every address, reads the word through the existing Hamming SEC-DED decoder, and writes back corrected words via the external encoder.
- Logs uncorrectable addresses and raises a sticky interrupt.

Parameters:
- DATA_WIDTH, 32, data word width.
- PARITY_LENGTH, 6, Hamming parity bits per word.
- ADDR_WIDTH, 10, bank address width.
- DEPTH, 1024, words in the bank; the last scrubbed address is DEPTH-1.
- INTERVAL_WIDTH, 16, width of the idle-gap counter between scrub reads.
- CNT_WIDTH, 16, width of the error counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- scrub_en  in  1  level enable for the scrub engine.
- scrub_interval  in  INTERVAL_WIDTH  idle cycles between words; sampled on entry to WAIT.
- host_req  in  1  host wants the port this cycle.
- host_we  in  1  host access is a write.
- host_addr  in  ADDR_WIDTH  host address.
- host_gnt  out  1  host owns the port this cycle (combinational, equals host_req).
- scr_sel  out  1  scrubber owns the port (external mux select).
- scr_en  out  1  scrubber memory enable.
- scr_we  out  1  scrubber write enable.
- scr_addr  out  ADDR_WIDTH  scrubber address.
- scr_wdata  out  DATA_WIDTH  corrected data to the encoder and memory.
- enc_parity_in  in  PARITY_LENGTH  encoder parity for scr_wdata.
- enc_oe_in  in  1  encoder overall-parity bit.
- scr_wparity  out  PARITY_LENGTH  equals enc_parity_in.
- scr_woe  out  1  equals enc_oe_in.
- dec_data_in  in  DATA_WIDTH  decoder registered corrected data.
- dec_label_in  in  3  decoder label: 1 ok, 2 corrected, 3 uncorrectable, 4 overall-parity-bit error.
- pass_done  out  1  one-cycle pulse when the address wraps.
- irq_uncorr  out  1  sticky uncorrectable flag.
- irq_clr  in  1  clears irq_uncorr.
- last_uncorr_addr  out  ADDR_WIDTH  address of the most recent label-3 word.

Behaviour:
- Reset: state IDLE, scrub address 0, all outputs 0, counters 0, hazard flag 0.
- Latency model: a read issued in cycle T gives memory data at T+1 and a valid decoder label and data at T+2.
- FSM states and transitions:
  - IDLE: when scrub_en=1, load the interval counter and go to WAIT.
  - WAIT: decrement each cycle; at 0 go to RD. An interval of 0 goes directly to RD on the next cycle.
  - RD: if host_req=1, stay in RD with no scrubber access. Else drive scr_sel=1, scr_en=1, scr_we=0, scr_addr=scrub address, clear the hazard flag, go to W1.
  - W1 -> W2 -> CHK, unconditionally.
  - CHK:
    - Hazard set: return to RD, same address, nothing counted.
    - Label 2 or 4: latch dec_data_in into scr_wdata, go to WB.
    - Label 3: last_uncorr_addr <= address, set irq_uncorr, go to NEXT.
    - Label 1 or 0: go to NEXT.
  - WB: if host_req=1, wait. If the hazard is set, go to RD. Else issue a write (scr_sel=scr_en=scr_we=1), go to NEXT.
  - NEXT: at DEPTH-1, wrap the address to 0 and pulse pass_done; otherwise increment. Then go to WAIT if scrub_en=1, else IDLE.
- Hazard flag: set in any cycle from W1 through WB when host_req & host_we & host_addr==scrub address. This prevents stale write-back over fresh host data.
- scr_sel is high only in the cycles where the scrubber drives an access. The host is never stalled.
- scrub_en deasserted mid-word: the engine completes the word through NEXT, then goes to IDLE. The address is retained and the next enable resumes from it.
- irq_uncorr: if set and irq_clr occur in the same cycle, set wins.
- Reset mid-operation: returns to IDLE immediately. An in-flight write-back is dropped.

Optional Feature:
- Macro ECC_SCRUB_STATS_EN.
- When defined, adds outputs corr_cnt (CNT_WIDTH) and uncorr_cnt (CNT_WIDTH). They increment in CHK on label 2/4 and label 3 respectively, saturate at all-ones, reset to 0, and are not incremented when the hazard is set.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Clean memory, DEPTH=16, interval=2, scrub_en=1 -> 16 reads, no writes, pass_done pulses once after address 15, irq_uncorr=0.
- Word 5 with a single data-bit flip (label 2) -> one write to address 5 with corrected data and encoder parity; corr_cnt=1 with ECC_SCRUB_STATS_EN.
- Word 9 with a double-bit error (label 3) -> no write, last_uncorr_addr=9, irq_uncorr=1 until irq_clr. Simultaneous irq_clr and a new label 3 keeps it at 1.
- host_req held high for 20 cycles while the engine is in RD -> host_gnt=1 and scr_sel=0 throughout; the scrub read issues on the first cycle after host_req drops.
- Host write to the scrubbed address during W2 of a label-2 word -> no write-back, the address is re-read, corr_cnt unchanged.
- scrub_en dropped in W1 at address 7 -> engine completes 7, goes to IDLE. Re-enable -> next read at address 8.
